// File: rtl/bus_cycle_ctlr.sv
// bus_cycle_ctlr
//   CPU-side external bus initiator. It accepts one internal access and runs
//   it as an external bus cycle. The cycle uses BCYSTn/DAn/BEn/RW/A/DO and
//   waits on READYn. When the responder asks for 16-bit transfers (SZRQn low
//   with READYn low), the access is finished as one or two half-word cycles
//   on the low data lanes.
//
// Ports
//   CLK, RESn, CE     clock, synchronous active-low reset, clock enable
//   REQ, REQ_WR       access request (level) and direction (1 = write)
//   REQ_A, REQ_BE     word address A[31:2] and active-high byte enables
//   REQ_WD            write data on its natural lanes
//   BUSY, ACK, BERR   access in progress, done pulse, wait-limit abort pulse
//   RD                read data on its natural lanes, disabled bytes zero
//   BCYSTn, DAn, RW   bus cycle start, data strobe, direction (1 = read)
//   A, BEn, DO        bus address, active-low byte enables, write data
//   DI, READYn, SZRQn bus read data, responder ready, 16-bit size request
module bus_cycle_ctlr #(
  parameter int WAIT_LIMIT = 0
) (
  input  logic        CLK,
  input  logic        RESn,
  input  logic        CE,
  input  logic        REQ,
  input  logic        REQ_WR,
  input  logic [29:0] REQ_A,
  input  logic [3:0]  REQ_BE,
  input  logic [31:0] REQ_WD,
  output logic        BUSY,
  output logic        ACK,
  output logic        BERR,
  output logic [31:0] RD,
  output logic        BCYSTn,
  output logic        DAn,
  output logic        RW,
  output logic [29:0] A,
  output logic [3:0]  BEn,
  output logic [31:0] DO,
  input  logic [31:0] DI,
  input  logic        READYn,
  input  logic        SZRQn
);

  typedef enum logic [2:0] {IDLE, T1, TW, T1H, TWH, DONE} state_t;

  localparam logic [15:0] LIMIT = 16'(WAIT_LIMIT);

  state_t      state, n_state;
  logic        wr_q, n_wr;
  logic [3:0]  be_q, n_be;
  logic [31:0] wd_q, n_wd;
  logic [15:0] cnt, n_cnt;
  logic        n_busy, n_ack, n_berr, n_bcyst, n_da, n_rw;
  logic [31:0] n_rd, n_do;
  logic [29:0] n_a;
  logic [3:0]  n_ben;
  logic        fin, abort_cyc, limit_hit;
  logic [31:0] fin_rd, mask;

  // Byte-lane mask of the latched access, used to zero disabled read bytes.
  assign mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
  assign limit_hit = (WAIT_LIMIT > 0) && (cnt == LIMIT);

  // Next-state and next-output logic. Every output is registered, so this
  // block computes the value each register takes on the next CE edge.
  // Finishing and aborting share one bus-release path below the case.
  always_comb begin
    n_state   = state;
    n_wr      = wr_q;
    n_be      = be_q;
    n_wd      = wd_q;
    n_cnt     = cnt;
    n_busy    = BUSY;
    n_ack     = ACK;
    n_berr    = BERR;
    n_rd      = RD;
    n_bcyst   = BCYSTn;
    n_da      = DAn;
    n_rw      = RW;
    n_a       = A;
    n_ben     = BEn;
    n_do      = DO;
    fin       = 1'b0;
    abort_cyc = 1'b0;
    fin_rd    = 32'h0;
    if (CE) begin
      case (state)
        IDLE: begin
          if (REQ) begin
            n_state = T1;
            n_wr    = REQ_WR;
            n_be    = REQ_BE;
            n_wd    = REQ_WD;
            n_cnt   = 16'h0;
            n_busy  = 1'b1;
            n_rd    = 32'h0;
            n_bcyst = 1'b0;
            n_da    = 1'b0;
            n_rw    = ~REQ_WR;
            n_a     = REQ_A;
            n_ben   = ~REQ_BE;
            // A high-only write puts the upper half on both lanes so a
            // 16-bit responder finds it on D[15:0].
            if (!REQ_WR)
              n_do = 32'h0;
            else if (REQ_BE[1:0] == 2'b00)
              n_do = {REQ_WD[31:16], REQ_WD[31:16]};
            else
              n_do = REQ_WD;
          end
        end
        T1, TW: begin
          if (READYn) begin
            if (state == TW && limit_hit) begin
              abort_cyc = 1'b1;
            end else begin
              n_state = TW;
              n_bcyst = 1'b1;
              n_cnt   = cnt + 16'h1;
            end
          end else if (SZRQn) begin
            fin    = 1'b1;
            fin_rd = DI & mask;
          end else if (be_q[1:0] != 2'b00) begin
            if (be_q[3:2] != 2'b00) begin
              // Low half taken now; the upper half needs a second cycle.
              n_state = T1H;
              n_rd    = {16'h0, DI[15:0] & mask[15:0]};
              n_bcyst = 1'b0;
              n_ben   = {~be_q[3:2], 2'b11};
              n_do    = wr_q ? {wd_q[31:16], wd_q[31:16]} : 32'h0;
              n_cnt   = 16'h0;
            end else begin
              fin    = 1'b1;
              fin_rd = {16'h0, DI[15:0] & mask[15:0]};
            end
          end else begin
            fin    = 1'b1;
            fin_rd = {DI[15:0] & mask[31:16], 16'h0};
          end
        end
        T1H, TWH: begin
          if (READYn) begin
            if (state == TWH && limit_hit) begin
              abort_cyc = 1'b1;
            end else begin
              n_state = TWH;
              n_bcyst = 1'b1;
              n_cnt   = cnt + 16'h1;
            end
          end else begin
            fin    = 1'b1;
            fin_rd = {DI[15:0] & mask[31:16], RD[15:0]};
          end
        end
        DONE: begin
          n_state = IDLE;
          n_ack   = 1'b0;
          n_berr  = 1'b0;
          n_busy  = 1'b0;
        end
        default: n_state = IDLE;
      endcase
      if (fin || abort_cyc) begin
        n_state = DONE;
        n_da    = 1'b1;
        n_bcyst = 1'b1;
        n_ben   = 4'hF;
        n_ack   = fin;
        n_berr  = abort_cyc;
        n_rd    = fin ? fin_rd : 32'h0;
      end
    end
  end

  // State and output registers. Reset wins over CE and abandons any cycle
  // in flight without signalling completion.
  always_ff @(posedge CLK) begin
    if (!RESn) begin
      state  <= IDLE;
      wr_q   <= 1'b0;
      be_q   <= 4'h0;
      wd_q   <= 32'h0;
      cnt    <= 16'h0;
      BUSY   <= 1'b0;
      ACK    <= 1'b0;
      BERR   <= 1'b0;
      RD     <= 32'h0;
      BCYSTn <= 1'b1;
      DAn    <= 1'b1;
      RW     <= 1'b1;
      A      <= 30'h0;
      BEn    <= 4'hF;
      DO     <= 32'h0;
    end else begin
      state  <= n_state;
      wr_q   <= n_wr;
      be_q   <= n_be;
      wd_q   <= n_wd;
      cnt    <= n_cnt;
      BUSY   <= n_busy;
      ACK    <= n_ack;
      BERR   <= n_berr;
      RD     <= n_rd;
      BCYSTn <= n_bcyst;
      DAn    <= n_da;
      RW     <= n_rw;
      A      <= n_a;
      BEn    <= n_ben;
      DO     <= n_do;
    end
  end

endmodule

// File: tb/tb_bus_cycle_ctlr.sv
// tb_bus_cycle_ctlr
//   Directed bench for bus_cycle_ctlr built with WAIT_LIMIT = 3. Each step
//   drives the request and responder inputs, advances one clock, and compares
//   outputs against hand-computed values.
module tb_bus_cycle_ctlr;

  logic        CLK, RESn, CE, REQ, REQ_WR;
  logic [29:0] REQ_A;
  logic [3:0]  REQ_BE;
  logic [31:0] REQ_WD;
  logic        BUSY, ACK, BERR, BCYSTn, DAn, RW;
  logic [31:0] RD, DO, DI;
  logic [29:0] A;
  logic [3:0]  BEn;
  logic        READYn, SZRQn;

  int checks = 0;
  int errors = 0;

  bus_cycle_ctlr #(.WAIT_LIMIT(3)) dut (
    .CLK(CLK), .RESn(RESn), .CE(CE), .REQ(REQ), .REQ_WR(REQ_WR),
    .REQ_A(REQ_A), .REQ_BE(REQ_BE), .REQ_WD(REQ_WD),
    .BUSY(BUSY), .ACK(ACK), .BERR(BERR), .RD(RD),
    .BCYSTn(BCYSTn), .DAn(DAn), .RW(RW), .A(A), .BEn(BEn), .DO(DO),
    .DI(DI), .READYn(READYn), .SZRQn(SZRQn)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Advance to just after the next rising edge.
  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  // Present a request. Only the byte-enable patterns the controller
  // supports are allowed.
  task automatic applyStimulus(input logic wr, input logic [29:0] addr,
                               input logic [3:0] be, input logic [31:0] wd);
    assert (be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                       4'b0011, 4'b1100, 4'b1111})
      else $error("[TB] illegal REQ_BE %b", be);
    REQ    = 1'b1;
    REQ_WR = wr;
    REQ_A  = addr;
    REQ_BE = be;
    REQ_WD = wd;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  initial begin
    RESn = 1'b0; CE = 1'b1; REQ = 1'b0; REQ_WR = 1'b0;
    REQ_A = '0; REQ_BE = 4'h0; REQ_WD = '0;
    DI = '0; READYn = 1'b1; SZRQn = 1'b1;
    cycle();
    cycle();
    checkOutput("rst_bcyst", 32'(BCYSTn), 32'h1);
    checkOutput("rst_dan",   32'(DAn),    32'h1);
    checkOutput("rst_rw",    32'(RW),     32'h1);
    checkOutput("rst_ben",   32'(BEn),    32'hF);
    checkOutput("rst_a",     32'(A),      32'h0);
    checkOutput("rst_do",    DO,          32'h0);
    checkOutput("rst_rd",    RD,          32'h0);
    checkOutput("rst_flags", {29'h0, ACK, BERR, BUSY}, 32'h0);
    RESn = 1'b1;
    cycle();

    $display("[TB] 32-bit read, no wait");
    applyStimulus(1'b0, 30'h100, 4'b1111, 32'h0);
    READYn = 1'b0; SZRQn = 1'b1; DI = 32'hDEADBEEF;
    cycle();
    REQ = 1'b0;
    checkOutput("rd32_t1_bcyst", 32'(BCYSTn), 32'h0);
    checkOutput("rd32_t1_dan",   32'(DAn),    32'h0);
    checkOutput("rd32_t1_ben",   32'(BEn),    32'h0);
    checkOutput("rd32_t1_rw",    32'(RW),     32'h1);
    checkOutput("rd32_t1_a",     32'(A),      32'h100);
    checkOutput("rd32_t1_busy",  32'(BUSY),   32'h1);
    cycle();
    checkOutput("rd32_ack",  32'(ACK), 32'h1);
    checkOutput("rd32_rd",   RD,       32'hDEADBEEF);
    checkOutput("rd32_dan",  32'(DAn), 32'h1);
    checkOutput("rd32_ben",  32'(BEn), 32'hF);
    cycle();
    checkOutput("rd32_ack_off",  32'(ACK),  32'h0);
    checkOutput("rd32_busy_off", 32'(BUSY), 32'h0);

    $display("[TB] 32-bit write, one wait");
    applyStimulus(1'b1, 30'h200, 4'b1111, 32'hCAFEF00D);
    READYn = 1'b1;
    cycle();
    REQ = 1'b0;
    checkOutput("wr1w_t1_bcyst", 32'(BCYSTn), 32'h0);
    checkOutput("wr1w_t1_dan",   32'(DAn),    32'h0);
    checkOutput("wr1w_t1_rw",    32'(RW),     32'h0);
    checkOutput("wr1w_do",       DO,          32'hCAFEF00D);
    cycle();
    READYn = 1'b0;
    checkOutput("wr1w_tw_bcyst", 32'(BCYSTn), 32'h1);
    checkOutput("wr1w_tw_dan",   32'(DAn),    32'h0);
    checkOutput("wr1w_tw_ack",   32'(ACK),    32'h0);
    cycle();
    checkOutput("wr1w_ack", 32'(ACK), 32'h1);
    checkOutput("wr1w_dan", 32'(DAn), 32'h1);
    cycle();

    $display("[TB] 16-bit split word write");
    applyStimulus(1'b1, 30'h300, 4'b1111, 32'h12345678);
    READYn = 1'b0; SZRQn = 1'b0;
    cycle();
    REQ = 1'b0;
    checkOutput("wr16_c1_ben",   32'(BEn),    32'h0);
    checkOutput("wr16_c1_do_lo", 32'(DO[15:0]), 32'h5678);
    checkOutput("wr16_c1_bcyst", 32'(BCYSTn), 32'h0);
    cycle();
    checkOutput("wr16_c2_ben",   32'(BEn),    32'h3);
    checkOutput("wr16_c2_do_lo", 32'(DO[15:0]), 32'h1234);
    checkOutput("wr16_c2_bcyst", 32'(BCYSTn), 32'h0);
    checkOutput("wr16_c2_dan",   32'(DAn),    32'h0);
    checkOutput("wr16_c2_ack",   32'(ACK),    32'h0);
    cycle();
    checkOutput("wr16_ack", 32'(ACK), 32'h1);
    cycle();
    checkOutput("wr16_ack_once", 32'(ACK), 32'h0);

    $display("[TB] 16-bit high-half read");
    applyStimulus(1'b0, 30'h040, 4'b1100, 32'h0);
    READYn = 1'b0; SZRQn = 1'b0; DI = 32'h5555ABCD;
    cycle();
    REQ = 1'b0;
    checkOutput("rdh_ben", 32'(BEn), 32'h3);
    checkOutput("rdh_do",  DO,       32'h0);
    cycle();
    checkOutput("rdh_ack", 32'(ACK), 32'h1);
    checkOutput("rdh_rd",  RD,       32'hABCD0000);
    cycle();

    $display("[TB] 32-bit byte read");
    applyStimulus(1'b0, 30'h041, 4'b0100, 32'h0);
    READYn = 1'b0; SZRQn = 1'b1; DI = 32'h11223344;
    cycle();
    REQ = 1'b0;
    checkOutput("rdb_ben", 32'(BEn), 32'hB);
    cycle();
    checkOutput("rdb_rd", RD, 32'h00220000);

    $display("[TB] clock enable stretches ACK");
    CE = 1'b0;
    cycle();
    cycle();
    checkOutput("ce_ack_hold",  32'(ACK),  32'h1);
    checkOutput("ce_busy_hold", 32'(BUSY), 32'h1);
    CE = 1'b1;
    cycle();
    checkOutput("ce_ack_off", 32'(ACK), 32'h0);

    $display("[TB] wait-limit abort");
    applyStimulus(1'b0, 30'h050, 4'b1111, 32'h0);
    READYn = 1'b1; SZRQn = 1'b1;
    cycle();
    REQ = 1'b0;
    cycle();
    cycle();
    cycle();
    checkOutput("berr_wait_dan",  32'(DAn),  32'h0);
    checkOutput("berr_wait_berr", 32'(BERR), 32'h0);
    cycle();
    checkOutput("berr_pulse", 32'(BERR), 32'h1);
    checkOutput("berr_noack", 32'(ACK),  32'h0);
    checkOutput("berr_dan",   32'(DAn),  32'h1);
    checkOutput("berr_rd",    RD,        32'h0);
    cycle();
    checkOutput("berr_off",  32'(BERR), 32'h0);
    checkOutput("berr_busy", 32'(BUSY), 32'h0);

    $display("[TB] reset during wait state");
    applyStimulus(1'b0, 30'h060, 4'b1111, 32'h0);
    READYn = 1'b1;
    cycle();
    REQ = 1'b0;
    cycle();
    checkOutput("rstw_dan_before", 32'(DAn), 32'h0);
    RESn = 1'b0;
    cycle();
    checkOutput("rstw_dan",   32'(DAn),    32'h1);
    checkOutput("rstw_bcyst", 32'(BCYSTn), 32'h1);
    checkOutput("rstw_ben",   32'(BEn),    32'hF);
    checkOutput("rstw_a",     32'(A),      32'h0);
    checkOutput("rstw_flags", {29'h0, ACK, BERR, BUSY}, 32'h0);
    RESn = 1'b1;
    READYn = 1'b0;
    cycle();
    checkOutput("rstw_noack", 32'(ACK), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
